// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_ctrl
//  Description : Serial "101" sequence detector with a word controller.
//                An accepted 8-bit word is scanned MSB first through a
//                Moore detector that counts overlapping or non-overlapping
//                "101" occurrences.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       ovl,
    output logic       busy,
    output logic       done,
    output logic       bit_out,
    output logic       det,
    output logic [2:0] count
);

    // Word controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctl_state_t;

    // Detector states: S<n> means the last n bits matched the prefix of "101"
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_t;

    localparam logic [3:0] C_LAST_IDX  = 4'd7;
    localparam logic [2:0] C_COUNT_MAX = 3'd7;

    ctl_state_t r_state, w_state_nxt;
    det_state_t r_dstate, w_dstate_nxt;
    det_state_t w_dstep;
    logic [7:0] r_sreg, w_sreg_nxt;
    logic [3:0] r_idx, w_idx_nxt;
    logic       r_mode, w_mode_nxt;
    logic [2:0] r_count, w_count_nxt;
    logic       w_x;

    // Register update; reset overrides any start or word in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_dstate <= S0;
            r_sreg   <= 8'd0;
            r_idx    <= 4'd0;
            r_mode   <= 1'b0;
            r_count  <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_dstate <= w_dstate_nxt;
            r_sreg   <= w_sreg_nxt;
            r_idx    <= w_idx_nxt;
            r_mode   <= w_mode_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Serial bit fed to the detector is always the MSB of the shift register
    assign w_x = r_sreg[7];

    // One detector step for the current serial bit and captured mode
    always_comb begin
        w_dstep = S0;
        case (r_dstate)
            S0:      w_dstep = w_x ? S1 : S0;
            S1:      w_dstep = w_x ? S1 : S2;
            S2:      w_dstep = w_x ? S3 : S0;
            S3:      w_dstep = w_x ? S1 : (r_mode ? S2 : S0);
            default: w_dstep = S0;
        endcase
    end

    // Controller next-state and datapath next values
    always_comb begin
        w_state_nxt  = r_state;
        w_dstate_nxt = r_dstate;
        w_sreg_nxt   = r_sreg;
        w_idx_nxt    = r_idx;
        w_mode_nxt   = r_mode;
        w_count_nxt  = r_count;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_sreg_nxt   = din;
                    w_mode_nxt   = ovl;
                    w_idx_nxt    = 4'd0;
                    w_dstate_nxt = S0;
                    w_count_nxt  = 3'd0;
                    w_state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                w_dstate_nxt = w_dstep;
                w_sreg_nxt   = {r_sreg[6:0], 1'b0};
                w_idx_nxt    = r_idx + 4'd1;
                if ((w_dstep == S3) && (r_count != C_COUNT_MAX)) begin
                    w_count_nxt = r_count + 3'd1;
                end
                if (r_idx == C_LAST_IDX) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; no input reaches them combinationally
    assign busy    = (r_state == SHIFT);
    assign done    = (r_state == DONE);
    assign bit_out = (r_state == SHIFT) & r_sreg[7];
    assign det     = (r_dstate == S3);
    assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_det_ctrl
//  Description : Directed, table-driven bench for seq_det_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       ovl;
    logic       busy;
    logic       done;
    logic       bit_out;
    logic       det;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    seq_det_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .ovl     (ovl),
        .busy    (busy),
        .done    (done),
        .bit_out (bit_out),
        .det     (det),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // trace bit k = expected det after shift edge k+1
    typedef struct {
        logic [7:0] din;
        logic       ovl;
        logic [2:0] cnt;
        logic [7:0] trace;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one word from a start pulse; optionally disturbs start/din/ovl
    // mid-word and pulses start during DONE.
    task automatic run_word(input logic [7:0] d, input logic o, input logic [2:0] cnt,
                            input logic [7:0] trace, input logic disturb);
        logic [7:0] sh;
        logic [2:0] exp_c;
        start = 1'b1;
        din   = d;
        ovl   = o;
        tick();
        start = 1'b0;
        chk("first busy", {7'd0, busy}, 8'd1);
        chk("first done", {7'd0, done}, 8'd0);
        chk("first bit_out", {7'd0, bit_out}, {7'd0, d[7]});
        chk("first det", {7'd0, det}, 8'd0);
        chk("first count", {5'd0, count}, 8'd0);
        exp_c = 3'd0;
        sh    = d;
        for (int i = 1; i <= 8; i++) begin
            if (disturb && i == 2) begin
                start = 1'b1;
                din   = ~d;
                ovl   = ~o;
            end
            if (disturb && i == 3) start = 1'b0;
            tick();
            exp_c = exp_c + {2'd0, trace[i-1]};
            sh    = {sh[6:0], 1'b0};
            if (i < 8) begin
                chk("shift busy", {7'd0, busy}, 8'd1);
                chk("shift done", {7'd0, done}, 8'd0);
                chk("shift bit_out", {7'd0, bit_out}, {7'd0, sh[7]});
                chk("shift det", {7'd0, det}, {7'd0, trace[i-1]});
                chk("shift count", {5'd0, count}, {5'd0, exp_c});
            end else begin
                chk("done pulse", {7'd0, done}, 8'd1);
                chk("done busy", {7'd0, busy}, 8'd0);
                chk("done bit_out", {7'd0, bit_out}, 8'd0);
                chk("done det", {7'd0, det}, {7'd0, trace[7]});
                chk("done count", {5'd0, count}, {5'd0, cnt});
            end
        end
        if (disturb) start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle done", {7'd0, done}, 8'd0);
        chk("idle busy", {7'd0, busy}, 8'd0);
        chk("idle count hold", {5'd0, count}, {5'd0, cnt});
        chk("idle det hold", {7'd0, det}, {7'd0, trace[7]});
        tick();
        chk("idle stays", {6'd0, busy, done}, 8'd0);
    endtask

    initial begin
        logic ok;
        vecs[0] = '{din: 8'hAA, ovl: 1'b1, cnt: 3'd3, trace: 8'h54};
        vecs[1] = '{din: 8'hAA, ovl: 1'b0, cnt: 3'd2, trace: 8'h44};
        vecs[2] = '{din: 8'h55, ovl: 1'b1, cnt: 3'd3, trace: 8'hA8};
        vecs[3] = '{din: 8'h55, ovl: 1'b0, cnt: 3'd2, trace: 8'h88};
        vecs[4] = '{din: 8'h00, ovl: 1'b1, cnt: 3'd0, trace: 8'h00};
        vecs[5] = '{din: 8'hFF, ovl: 1'b1, cnt: 3'd0, trace: 8'h00};
        vecs[6] = '{din: 8'hA5, ovl: 1'b0, cnt: 3'd2, trace: 8'h84};

        rst   = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        ovl   = 1'b0;
        tick();
        tick();
        chk("reset outputs", {3'd0, busy, done, bit_out, det, 1'b0}, 8'd0);
        chk("reset count", {5'd0, count}, 8'd0);
        rst = 1'b0;

        // Table of words, first one launched right after reset release
        for (int v = 0; v < 7; v++) begin
            run_word(vecs[v].din, vecs[v].ovl, vecs[v].cnt, vecs[v].trace, 1'b0);
        end

        // Disturbances during SHIFT/DONE must not affect the word
        run_word(8'hAA, 1'b1, 3'd3, 8'h54, 1'b1);
        run_word(8'hA5, 1'b0, 3'd2, 8'h84, 1'b1);

        // Held start: second word begins after the IDLE cycle following DONE
        start = 1'b1;
        din   = 8'hA5;
        ovl   = 1'b0;
        tick();
        chk("held busy", {7'd0, busy}, 8'd1);
        for (int i = 0; i < 8; i++) tick();
        chk("held done", {7'd0, done}, 8'd1);
        chk("held count", {5'd0, count}, 8'd2);
        tick();
        chk("held idle", {6'd0, busy, done}, 8'd0);
        chk("held idle count", {5'd0, count}, 8'd2);
        tick();
        chk("held restart busy", {7'd0, busy}, 8'd1);
        chk("held restart count", {5'd0, count}, 8'd0);
        chk("held restart det", {7'd0, det}, 8'd0);
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("held2 done", {7'd0, done}, 8'd1);
        chk("held2 count", {5'd0, count}, 8'd2);
        tick();

        // Reset at SHIFT edge 4 aborts the word with no done pulse
        start = 1'b1;
        din   = 8'hAA;
        ovl   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre-abort det", {7'd0, det}, 8'd1);
        chk("pre-abort count", {5'd0, count}, 8'd1);
        rst = 1'b1;
        tick();
        chk("abort outputs", {3'd0, busy, done, bit_out, det, 1'b0}, 8'd0);
        chk("abort count", {5'd0, count}, 8'd0);
        rst = 1'b0;
        ok  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("no done after abort", {7'd0, ok}, 8'd1);
        run_word(8'hAA, 1'b1, 3'd3, 8'h54, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
